mat2x2_inv: RTL

Sequential modular inverter for packed 2x2 matrices of 8-bit elements over Z/256. It is the inverse companion of the team's combinational 2x2 matrix product block. Given matrix A, it returns B such that the product A·B (mod 256, same packing) equals the identity, and it flags A as singular when det(A) is even. It sits behind a valid/ready producer and feeds a valid/ready consumer; throughput is one matrix per multi-cycle transaction.

---
 rtl/mat2x2_pkg.sv | 42 ++++
 rtl/inv8_newton.sv | 16 +
 rtl/mat2x2_inv.sv | 113 +++++++++++
 3 files changed

// File: rtl/mat2x2_pkg.sv
// Shared types and constants for the 2x2 mod-256 matrix inverter.
// MAT2X2_INV_VERIFY_EN adds the CHECK state to the FSM encoding.
package mat2x2_pkg;

  typedef logic [7:0] elem_t;

  typedef struct packed {
    elem_t m11;
    elem_t m10;
    elem_t m01;
    elem_t m00;
  } mat_t;

  typedef enum logic [2:0] {
    IDLE,
    DET,
    NEWT0,
    NEWT1,
    ADJ,
`ifdef MAT2X2_INV_VERIFY_EN
    CHECK,
`endif
    DONE
  } state_t;

  localparam int unsigned NEWTON_ITERS = 2;
  localparam logic [31:0] IDENT_PACKED = 32'h01000001;

  function automatic mat_t unpack_mat(input logic [31:0] p);
    mat_t m;
    m.m00 = p[7:0];
    m.m01 = p[15:8];
    m.m10 = p[23:16];
    m.m11 = p[31:24];
    return m;
  endfunction

  function automatic logic [31:0] pack_mat(input mat_t m);
    return {m.m11, m.m10, m.m01, m.m00};
  endfunction

endpackage

// File: rtl/inv8_newton.sv
// One Newton step toward the multiplicative inverse of d mod 256:
// x' = x * (2 - d*x). Each step doubles the number of correct low bits.
module inv8_newton
  import mat2x2_pkg::*;
(
  input  elem_t d,
  input  elem_t x,
  output elem_t x_next
);

  elem_t dx;

  assign dx     = d * x;
  assign x_next = x * (8'd2 - dx);

endmodule

// File: rtl/mat2x2_inv.sv
// Sequential inverter for packed 2x2 matrices over Z/256 with valid/ready ports.
// Define MAT2X2_INV_VERIFY_EN to add a CHECK state that multiplies A*B back.
module mat2x2_inv
  import mat2x2_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_mat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_mat,
  output logic        out_singular,
  output logic        out_check_fail
);

  state_t state, state_next;
  mat_t   a_reg;
  mat_t   adj;
  elem_t  d_reg, x_reg, x_step, d_comb;
  logic   singular;

  assign d_comb = a_reg.m00 * a_reg.m11 - a_reg.m01 * a_reg.m10;

  // Single shared Newton stage, reused in NEWT0 and NEWT1.
  inv8_newton u_newton (
    .d      (d_reg),
    .x      (x_reg),
    .x_next (x_step)
  );

  always_comb begin
    adj.m00 = x_reg * a_reg.m11;
    adj.m01 = 8'd0 - x_reg * a_reg.m01;
    adj.m10 = 8'd0 - x_reg * a_reg.m10;
    adj.m11 = x_reg * a_reg.m00;
  end

  // NOTE: state_next gets its default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid && in_ready) state_next = DET;
      DET:     state_next = NEWT0;
      NEWT0:   state_next = (NEWTON_ITERS > 1) ? NEWT1 : ADJ;
      NEWT1:   state_next = ADJ;
`ifdef MAT2X2_INV_VERIFY_EN
      ADJ:     state_next = CHECK;
      CHECK:   state_next = DONE;
`else
      ADJ:     state_next = DONE;
`endif
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef MAT2X2_INV_VERIFY_EN
  mat_t        b_chk, c_chk;
  logic [31:0] c_packed;

  assign b_chk = unpack_mat(out_mat);

  always_comb begin
    c_chk.m00 = a_reg.m00 * b_chk.m00 + a_reg.m01 * b_chk.m10;
    c_chk.m01 = a_reg.m00 * b_chk.m01 + a_reg.m01 * b_chk.m11;
    c_chk.m10 = a_reg.m10 * b_chk.m00 + a_reg.m11 * b_chk.m10;
    c_chk.m11 = a_reg.m10 * b_chk.m01 + a_reg.m11 * b_chk.m11;
  end

  assign c_packed = pack_mat(c_chk);
`else
  assign out_check_fail = 1'b0;
`endif

  // Control and visible outputs: cleared by reset so an aborted job never leaks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_mat      <= '0;
      out_singular <= 1'b0;
`ifdef MAT2X2_INV_VERIFY_EN
      out_check_fail <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if (state == ADJ) begin
        out_mat      <= singular ? '0 : pack_mat(adj);
        out_singular <= singular;
      end
`ifdef MAT2X2_INV_VERIFY_EN
      if (state == CHECK) out_check_fail <= !singular && (c_packed != IDENT_PACKED);
`endif
    end
  end

  // NOTE: operand registers are deliberately unreset; they are always written before any state reads them.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid && in_ready) a_reg <= unpack_mat(in_mat);
    if (state == DET) begin
      d_reg    <= d_comb;
      x_reg    <= d_comb;
      singular <= ~d_comb[0];
    end
    if (state == NEWT0 || state == NEWT1) x_reg <= x_step;
  end

endmodule
